// File: rtl/shift_seq.sv
// Sequential barrel-shift replacement: moves a 32-bit operand one bit per cycle
// (SHL/SHR/SHRA/ROL/ROR) and presents the result with a one-cycle done pulse.
module shift_seq (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic signed [31:0] data_in,
   input  logic signed [31:0] shift_amount,
   output logic signed [31:0] data_out,
   output logic               busy,
   output logic               done,
   output logic               op_err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [2:0] OP_SHL  = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHRA = 3'b010;
   localparam logic [2:0] OP_ROL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;

   state_t      state;
   logic [31:0] work;
   logic [4:0]  count;
   logic [2:0]  op_reg;
   logic        illegal;
   logic        zero_amount;
   logic [31:0] next_work;
   logic        unused_amount_hi;

   // Only the low five bits select a distance; the rest is deliberately dropped.
   assign unused_amount_hi = ^shift_amount[31:5];

   function automatic logic [31:0] step(input logic [2:0] o, input logic [31:0] v);
      logic [31:0] r;
      r = v;
      case (o)
         OP_SHL:  r = {v[30:0], 1'b0};
         OP_SHR:  r = {1'b0, v[31:1]};
         OP_SHRA: r = {v[31], v[31:1]};
         OP_ROL:  r = {v[30:0], v[31]};
         OP_ROR:  r = {v[0], v[31:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign illegal     = (op > OP_ROR);
   assign zero_amount = (shift_amount[4:0] == 5'd0);
   assign next_work   = step(op_reg, work);

   // data_out is only loaded when entering DONE, so SHIFT intermediates never leak out.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         work     <= '0;
         count    <= '0;
         op_reg   <= '0;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         op_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work   <= data_in;
                  count  <= shift_amount[4:0];
                  op_reg <= op;
                  busy   <= 1'b1;
                  if (illegal || zero_amount) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     op_err   <= illegal;
                     data_out <= data_in;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= next_work;
               count <= count - 5'd1;
               if (count == 5'd1) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  data_out <= $signed(next_work);
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               op_err <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               op_err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list, in order:
- clock: input, 1 bit; rising-edge clock.
- clear: input, 1 bit; asynchronous, active-low reset.
- start: input, 1 bit; operation request, sampled only in IDLE.
- op: input, 3 bits; 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 illegal.
- data_in: input, signed 32 bits; operand to shift.
- shift_amount: input, signed 32 bits; only [4:0] used, [31:5] ignored.
- data_out: output, signed 32 bits; result register, feeds the Z register/bus.
- busy: output, 1 bit; high in SHIFT and DONE.
- done: output, 1 bit; one-cycle completion pulse.
- op_err: output, 1 bit; high with done when op was illegal.

Function
REQ-003 State machine SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-004 IDLE, start=1 at a rising edge SHALL capture data_in into the work register, shift_amount[4:0] into a 5-bit counter, and op into an op register.
REQ-005 IDLE exit on start SHALL be: DONE if op is illegal or shift_amount[4:0]=0, otherwise SHIFT.
REQ-006 IDLE with start=0 SHALL hold all registers and stay in IDLE.
REQ-007 SHIFT SHALL, each cycle, move the work register by exactly one bit per the captured op and decrement the counter by 1.
- SHL: insert 0 at bit 0.
- SHR: insert 0 at bit 31.
- SHRA: replicate bit 31.
- ROL: bit 31 moves to bit 0.
- ROR: bit 0 moves to bit 31.
REQ-008 SHIFT SHALL go to DONE on the edge where the counter decrements from 1 to 0.
REQ-009 DONE SHALL assert done for exactly one cycle and present the final work register on data_out, then return to IDLE unconditionally.
REQ-010 Latency from the start edge to done high SHALL be n+1 cycles for n=shift_amount[4:0]≥1, and 1 cycle for n=0 or an illegal op.
REQ-011 data_out SHALL hold the last result from the end of DONE until the next DONE; it SHALL NOT reflect intermediate SHIFT values.
REQ-012 start SHALL be ignored while busy=1, including in the DONE cycle; it is not queued.
REQ-013 An illegal op SHALL yield data_out=captured data_in unchanged and op_err=1 in the DONE cycle; op_err SHALL be 0 in all other cycles.
REQ-014 Inputs data_in, shift_amount and op SHALL only matter at the accepting start edge; changes mid-operation SHALL have no effect.
REQ-015 Result SHALL equal the combinational shift by shift_amount[4:0]: SHL matches <<, SHR matches logical >>, SHRA matches arithmetic >>>, and rotates are modulo 32.

Reset
REQ-016 clear=0 SHALL, asynchronously and regardless of state, force IDLE and set data_out=0, busy=0, done=0, op_err=0, counter=0 and the work register to 0.
REQ-017 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after clear rises SHALL be accepted normally.
REQ-018 After clear deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-019 SHL: data_in=5, amount=3 -> done 4 cycles after the start edge, data_out=40 (0x00000028).
REQ-020 SHRA/SHR: data_in=-8 (0xFFFFFFF8), amount=2 -> SHRA gives 0xFFFFFFFE (-2); SHR gives 0x3FFFFFFE.
REQ-021 Rotates: ROR 0x00000001 by 1 -> 0x80000000 in 2 cycles; ROL 0x80000001 by 4 -> 0x00000018.
REQ-022 Boundaries:
- amount=32 (low bits 0) -> done after 1 cycle, data_out=data_in.
- amount=31 SHL of 1 -> 0x80000000 after 32 cycles.
- op=111 -> op_err=1, data_out=data_in.
REQ-023 Busy/reset:
- A second start pulsed during SHIFT -> ignored, and the first result is unchanged.
- clear=0 asserted mid-SHIFT -> all outputs 0 immediately and no done pulse.
